vga_term_writer: RTL and testbench
==================================

Name: vga_term_writer

Overview:
- Character-stream terminal front end that sits directly upstream of the VGA character memory and drives its write port (we, wr_addr, wc_addr, w_ascii, w_fg_color, w_bg_color).
- Accepts one byte per valid/ready handshake and tracks a cursor.
- Handles printable characters, CR, LF, backspace and form-feed.
- Wraps to row 0 after the bottom row and blanks each row it enters, so no read-back of character memory is needed.

Parameters:
- ROWS, 29, number of text rows (row index 0..ROWS-1, fits 5 bits).
- COLS, 69, number of text columns (column index 0..COLS-1, fits 7 bits).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  block can accept a byte this cycle.
- in_char  in  8  ASCII byte.
- in_fg_color  in  3  foreground colour, sampled with the byte.
- in_bg_color  in  3  background colour, sampled with the byte.
- we  out  1  character-memory write enable.
- wr_addr  out  5  write row.
- wc_addr  out  7  write column.
- w_ascii  out  8  write character.
- w_fg_color  out  3  write foreground colour.
- w_bg_color  out  3  write background colour.
- cursor_row  out  5  current cursor row.
- cursor_col  out  7  current cursor column.
- busy  out  1  a clear sequence is in progress.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state=CLEAR_ALL; cursor_row=0, cursor_col=0.
  - we=0; wr_addr=0, wc_addr=0; w_ascii=0x20; w_fg_color=3'b111, w_bg_color=0.
  - Clear counters=0; latched colours fg=7, bg=0.
  - The screen is therefore fully blanked after every reset.
- Output timing:
  - All write-port outputs are registered.
  - A byte accepted at edge N gives we=1 with its address/data during cycle N..N+1; the memory captures it at edge N+1.
  - we is high for exactly one cycle per write.
- Handshake:
  - in_ready = (state==IDLE), combinational from state.
  - Accept = in_valid & in_ready; in_char and the colours are sampled at the accept edge.
  - in_valid may stay high while in_ready is low, with no loss or duplication.
- States: IDLE, CLEAR_LINE, CLEAR_ALL. busy = (state != IDLE).
- IDLE, on accept, by byte value:
  - Printable 0x20..0x7E:
    - Write {row, col, char, fg, bg}.
    - If col < COLS-1: col+1.
    - Else: col=0, then advance-row.
  - 0x0D (CR): col=0, no write.
  - 0x0A (LF): col=0, then advance-row, no write.
  - 0x08 (BS):
    - If col > 0: col-1 and write 0x20 with the sampled colours at the new col.
    - If col == 0: no-op (no write, no row change).
  - 0x0C (FF): latch colours; cursor=(0,0); go to CLEAR_ALL.
  - Any other byte: consumed, no write, cursor unchanged.
- Advance-row:
  - row = (row==ROWS-1) ? 0 : row+1.
  - Latch the sampled colours; clear column counter=0; go to CLEAR_LINE on the new row.
  - Cursor outputs show the new position immediately.
- CLEAR_LINE:
  - Each cycle writes 0x20 with the latched fg/bg at (cursor_row, k) for k=0..COLS-1.
  - Exactly COLS consecutive we cycles; returns to IDLE after the write at k=COLS-1.
  - When a printable character at col COLS-1 triggers the wrap, that character's write happens on the cycle before the first clear write.
- CLEAR_ALL:
  - Writes 0x20 row-major: row 0..ROWS-1, col 0..COLS-1.
  - Exactly ROWS*COLS = 2001 consecutive we cycles, then IDLE.
  - The cursor is (0,0) throughout.
- Reset asserted mid-clear or mid-write:
  - Immediate asynchronous return to reset values, including we=0.
  - A fresh CLEAR_ALL starts after deassertion.
- Addresses never exceed ROWS-1 / COLS-1 on any cycle where we=1.

Decomposition:
- Shared package (vga_pkg):
  - Constants TEXT_ROWS=29, TEXT_COLS=69.
  - ASCII constants CH_SPACE, CH_BS, CH_LF, CH_CR, CH_FF.
  - Typedef color_t = logic [2:0].
  - State enum term_state_t.
- No sub-module is needed: a single FSM with cursor and clear counters. It instantiates nothing and connects port-to-port to the character memory's write side.

Test Plan:
- Reset then idle: in_ready=0 for 2001 cycles with we=1 each cycle; last write at (28,68) is 0x20; then in_ready=1, cursor (0,0).
- Send 'A' (0x41) with fg=2, bg=5 at (0,0): next cycle we=1, addr (0,0), w_ascii=0x41, fg=2, bg=5; cursor becomes (0,1).
- Send 69 x 'B' from (3,0): 69 writes to cols 0..68, then 69 clear writes on row 4; cursor ends at (4,0); in_ready is low for exactly 69 cycles.
- LF at row 28, col 10: cursor becomes (0,0) and row 0 gets 69 space writes. CR at (5,7) gives cursor (5,0) with no write.
- BS at (2,5): writes 0x20 at (2,4) and cursor becomes (2,4). BS at (2,0): no write, cursor unchanged. Byte 0x07: consumed, no write.
- FF during IDLE: full 2001-cycle clear and cursor (0,0). Assert rst_n low during cycle 1000 of the clear: we drops at once, and the clear restarts from (0,0) after release.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Brief    : Shared text-geometry, ASCII and state definitions for the VGA
//            character terminal writer.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int TEXT_ROWS = 29;
    localparam int TEXT_COLS = 69;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_FF    = 8'h0C;

    typedef logic [2:0] color_t;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_CLEAR_LINE = 2'd1,
        ST_CLEAR_ALL  = 2'd2
    } term_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_term_writer.sv
`default_nettype none
// ============================================================================
// Module   : vga_term_writer
// Brief    : Byte-stream terminal front end driving the write port of the VGA
//            character memory; tracks a cursor and blanks rows it enters.
// Revision : 1.0 - initial release
// ============================================================================
module vga_term_writer
    import vga_pkg::*;
#(
    parameter int ROWS = TEXT_ROWS,
    parameter int COLS = TEXT_COLS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    input  color_t     in_fg_color,
    input  color_t     in_bg_color,
    output logic       we,
    output logic [4:0] wr_addr,
    output logic [6:0] wc_addr,
    output logic [7:0] w_ascii,
    output color_t     w_fg_color,
    output color_t     w_bg_color,
    output logic [4:0] cursor_row,
    output logic [6:0] cursor_col,
    output logic       busy
);

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);

    term_state_t r_state;
    logic [4:0]  r_row;
    logic [6:0]  r_col;
    logic [4:0]  r_clr_row;
    logic [6:0]  r_clr_col;
    color_t      r_fg_lat;
    color_t      r_bg_lat;

    logic        r_we;
    logic [4:0]  r_wr_addr;
    logic [6:0]  r_wc_addr;
    logic [7:0]  r_ascii;
    color_t      r_wfg;
    color_t      r_wbg;

    logic        w_accept;
    logic        w_printable;
    logic [4:0]  w_next_row;

    assign in_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign w_accept    = in_valid & in_ready;
    assign w_printable = (in_char >= 8'h20) && (in_char <= 8'h7E);
    assign w_next_row  = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;

    assign we         = r_we;
    assign wr_addr    = r_wr_addr;
    assign wc_addr    = r_wc_addr;
    assign w_ascii    = r_ascii;
    assign w_fg_color = r_wfg;
    assign w_bg_color = r_wbg;
    assign cursor_row = r_row;
    assign cursor_col = r_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR_ALL;
            r_row     <= 5'd0;
            r_col     <= 7'd0;
            r_clr_row <= 5'd0;
            r_clr_col <= 7'd0;
            r_fg_lat  <= 3'b111;
            r_bg_lat  <= 3'b000;
            r_we      <= 1'b0;
            r_wr_addr <= 5'd0;
            r_wc_addr <= 7'd0;
            r_ascii   <= CH_SPACE;
            r_wfg     <= 3'b111;
            r_wbg     <= 3'b000;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_printable) begin
                            r_we      <= 1'b1;
                            r_wr_addr <= r_row;
                            r_wc_addr <= r_col;
                            r_ascii   <= in_char;
                            r_wfg     <= in_fg_color;
                            r_wbg     <= in_bg_color;
                            if (r_col < LAST_COL) begin
                                r_col <= r_col + 7'd1;
                            end else begin
                                r_col     <= 7'd0;
                                r_row     <= w_next_row;
                                r_fg_lat  <= in_fg_color;
                                r_bg_lat  <= in_bg_color;
                                r_clr_col <= 7'd0;
                                r_state   <= ST_CLEAR_LINE;
                            end
                        end else begin
                            case (in_char)
                                CH_CR: r_col <= 7'd0;
                                CH_LF: begin
                                    r_col     <= 7'd0;
                                    r_row     <= w_next_row;
                                    r_fg_lat  <= in_fg_color;
                                    r_bg_lat  <= in_bg_color;
                                    r_clr_col <= 7'd0;
                                    r_state   <= ST_CLEAR_LINE;
                                end
                                CH_BS: begin
                                    // Erase the cell the cursor steps back onto
                                    if (r_col != 7'd0) begin
                                        r_col     <= r_col - 7'd1;
                                        r_we      <= 1'b1;
                                        r_wr_addr <= r_row;
                                        r_wc_addr <= r_col - 7'd1;
                                        r_ascii   <= CH_SPACE;
                                        r_wfg     <= in_fg_color;
                                        r_wbg     <= in_bg_color;
                                    end
                                end
                                CH_FF: begin
                                    r_fg_lat  <= in_fg_color;
                                    r_bg_lat  <= in_bg_color;
                                    r_row     <= 5'd0;
                                    r_col     <= 7'd0;
                                    r_clr_row <= 5'd0;
                                    r_clr_col <= 7'd0;
                                    r_state   <= ST_CLEAR_ALL;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_CLEAR_LINE: begin
                    r_we      <= 1'b1;
                    r_wr_addr <= r_row;
                    r_wc_addr <= r_clr_col;
                    r_ascii   <= CH_SPACE;
                    r_wfg     <= r_fg_lat;
                    r_wbg     <= r_bg_lat;
                    if (r_clr_col == LAST_COL) begin
                        r_clr_col <= 7'd0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_clr_col <= r_clr_col + 7'd1;
                    end
                end
                ST_CLEAR_ALL: begin
                    r_we      <= 1'b1;
                    r_wr_addr <= r_clr_row;
                    r_wc_addr <= r_clr_col;
                    r_ascii   <= CH_SPACE;
                    r_wfg     <= r_fg_lat;
                    r_wbg     <= r_bg_lat;
                    if (r_clr_col == LAST_COL) begin
                        r_clr_col <= 7'd0;
                        if (r_clr_row == LAST_ROW) begin
                            r_clr_row <= 5'd0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_clr_row <= r_clr_row + 5'd1;
                        end
                    end else begin
                        r_clr_col <= r_clr_col + 7'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_term_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_term_writer
// Brief    : Self-checking bench for vga_term_writer against a cell-level
//            model of expected character-memory writes and cursor position.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_term_writer;

    localparam int ROWS = 29;
    localparam int COLS = 69;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic [2:0] in_fg_color;
    logic [2:0] in_bg_color;
    logic       we;
    logic [4:0] wr_addr;
    logic [6:0] wc_addr;
    logic [7:0] w_ascii;
    logic [2:0] w_fg_color;
    logic [2:0] w_bg_color;
    logic [4:0] cursor_row;
    logic [6:0] cursor_col;
    logic       busy;

    vga_term_writer #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .in_fg_color(in_fg_color),
        .in_bg_color(in_bg_color),
        .we         (we),
        .wr_addr    (wr_addr),
        .wc_addr    (wc_addr),
        .w_ascii    (w_ascii),
        .w_fg_color (w_fg_color),
        .w_bg_color (w_bg_color),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         r;
        int         c;
        logic [7:0] ch;
        logic [2:0] f;
        logic [2:0] b;
    } wr_t;

    wr_t q[$];
    int  mr;
    int  mc;
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push_w(input int r, input int c, input logic [7:0] ch,
                          input logic [2:0] f, input logic [2:0] b);
        wr_t w;
        w.r = r; w.c = c; w.ch = ch; w.f = f; w.b = b;
        q.push_back(w);
    endtask

    task automatic model_reset();
        q.delete();
        mr = 0;
        mc = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                push_w(r, c, 8'h20, 3'd7, 3'd0);
    endtask

    task automatic model_newline(input logic [2:0] f, input logic [2:0] b);
        mc = 0;
        mr = (mr + 1) % ROWS;
        for (int c = 0; c < COLS; c++) push_w(mr, c, 8'h20, f, b);
    endtask

    task automatic model_accept(input logic [7:0] ch, input logic [2:0] f, input logic [2:0] b);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            push_w(mr, mc, ch, f, b);
            if (mc < COLS - 1) mc++;
            else model_newline(f, b);
        end else if (ch == 8'h0D) begin
            mc = 0;
        end else if (ch == 8'h0A) begin
            model_newline(f, b);
        end else if (ch == 8'h08) begin
            if (mc > 0) begin
                mc--;
                push_w(mr, mc, 8'h20, f, b);
            end
        end else if (ch == 8'h0C) begin
            mr = 0;
            mc = 0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    push_w(r, c, 8'h20, f, b);
        end
    endtask

    // Every write the DUT issues must be the next expected cell update
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("we_in_reset", {31'd0, we}, 32'd0);
        end else begin
            chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~in_ready});
            if (we === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = q.pop_front();
                    chk("write", {wr_addr, wc_addr, w_ascii, w_fg_color, w_bg_color},
                        {5'(e.r), 7'(e.c), e.ch, e.f, e.b});
                end
            end
        end
    end

    task automatic send(input logic [7:0] ch, input logic [2:0] f, input logic [2:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_char = ch; in_fg_color = f; in_bg_color = b;
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("send_timeout", 32'd1, 32'd0);
        else model_accept(ch, f, b);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_cursor(input string nm, input int r, input int c);
        chk(nm, {cursor_row, cursor_col}, {5'(r), 7'(c)});
    endtask

    initial begin
        int cnt;
        int lim;
        logic [19:0] last;

        rst_n = 1'b0; in_valid = 1'b0; in_char = 8'h00;
        in_fg_color = 3'd0; in_bg_color = 3'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_data", {wr_addr, wc_addr, w_ascii, w_fg_color, w_bg_color},
            {5'd0, 7'd0, 8'h20, 3'd7, 3'd0});
        chk("rst_ready_busy", {30'd0, in_ready, busy}, 32'd1);
        chk_cursor("rst_cursor", 0, 0);
        #2 rst_n = 1'b1;

        // Full-screen blanking after reset: count the unbroken run of writes
        cnt = 0; lim = 0; last = '0;
        while (lim < 3000) begin
            @(negedge clk);
            lim++;
            if (we) begin
                cnt++;
                last = {wr_addr, wc_addr, w_ascii};
            end else if (cnt > 0) begin
                break;
            end
        end
        chk("init_clear_count", cnt, 2001);
        chk("init_clear_last", last, {5'd28, 7'd68, 8'h20});
        chk("init_ready", {31'd0, in_ready}, 32'd1);
        chk_cursor("init_cursor", 0, 0);

        send(8'h41, 3'd2, 3'd5);
        chk("A_write", {we, wr_addr, wc_addr, w_ascii, w_fg_color, w_bg_color},
            {1'b1, 5'd0, 7'd0, 8'h41, 3'd2, 3'd5});
        chk_cursor("A_cursor", 0, 1);

        send(8'h0D, 3'd1, 3'd0);
        for (int i = 0; i < 3; i++) send(8'h0A, 3'd3, 3'd4);
        wait_idle();
        chk_cursor("to_row3", 3, 0);

        for (int i = 0; i < 69; i++) send(8'h42, 3'd6, 3'd1);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) break;
            cnt++;
        end
        chk("wrap_busy_cycles", cnt, 69);
        chk_cursor("wrap_cursor", 4, 0);

        for (int i = 0; i < 24; i++) send(8'h0A, 3'd0, 3'd2);
        for (int i = 0; i < 10; i++) send(8'h61 + 8'(i), 3'd5, 3'd0);
        wait_idle();
        chk_cursor("row28_col10", 28, 10);
        send(8'h0A, 3'd7, 3'd3);
        chk_cursor("lf_bottom_wrap", 0, 0);
        wait_idle();

        for (int i = 0; i < 5; i++) send(8'h0A, 3'd7, 3'd0);
        for (int i = 0; i < 7; i++) send(8'h7E, 3'd1, 3'd1);
        wait_idle();
        send(8'h0D, 3'd2, 3'd2);
        #1 chk("cr_no_write", {31'd0, we}, 32'd0);
        chk_cursor("cr_cursor", 5, 0);

        send(8'h0C, 3'd6, 3'd3);
        wait_idle();
        chk_cursor("ff_cursor", 0, 0);

        send(8'h0A, 3'd7, 3'd0);
        send(8'h0A, 3'd7, 3'd0);
        for (int i = 0; i < 5; i++) send(8'h20, 3'd4, 3'd4);
        wait_idle();
        send(8'h08, 3'd3, 3'd6);
        chk("bs_write", {we, wr_addr, wc_addr, w_ascii, w_fg_color, w_bg_color},
            {1'b1, 5'd2, 7'd4, 8'h20, 3'd3, 3'd6});
        chk_cursor("bs_cursor", 2, 4);
        send(8'h0D, 3'd0, 3'd0);
        send(8'h08, 3'd1, 3'd1);
        #1 chk("bs_col0_no_write", {31'd0, we}, 32'd0);
        chk_cursor("bs_col0_cursor", 2, 0);
        send(8'h07, 3'd1, 3'd1);
        #1 chk("other_no_write", {31'd0, we}, 32'd0);
        chk_cursor("other_cursor", 2, 0);
        repeat (4) @(negedge clk);

        // Reset in the middle of a form-feed clear
        send(8'h0C, 3'd4, 3'd1);
        cnt = 0; lim = 0;
        while (cnt < 1000 && lim < 3000) begin
            @(negedge clk);
            lim++;
            if (we) cnt++;
        end
        chk("ff_mid_count", cnt, 1000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_we", {31'd0, we}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        chk_cursor("midrst_cursor", 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("restart_first", {we, wr_addr, wc_addr, w_fg_color}, {1'b1, 5'd0, 7'd0, 3'd7});
        wait_idle();
        chk_cursor("restart_cursor", 0, 0);
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
